// File: rtl/ring_if.sv
// Handshake bundle between a ring-counter source and the ring_decoder.
// The master drives the observed word; the slave (decoder) returns the decode.
interface ring_if #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH)
);
    logic [WIDTH-1:0] count_in;
    logic             in_valid;
    logic [IDXW-1:0]  index;
    logic             index_valid;
    logic             locked;
    logic             wrap_pulse;
    logic             err_pulse;
    logic [7:0]       err_count;

    modport master (
        output count_in, in_valid,
        input  index, index_valid, locked, wrap_pulse, err_pulse, err_count
    );

    modport slave (
        input  count_in, in_valid,
        output index, index_valid, locked, wrap_pulse, err_pulse, err_count
    );
endinterface

// File: rtl/ring_decoder.sv
// One-hot ring-counter decoder: validates the rotate-right sequence, locks after
// LOCK_N consecutive in-sequence steps and reports index, wrap and error events.
module ring_decoder #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3,
    parameter int IDXW   = $clog2(WIDTH)
) (
    input logic   clk,
    input logic   reset,
    ring_if.slave bus
);
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

    function automatic logic is_onehot(input logic [WIDTH-1:0] w);
        return (w != '0) && ((w & (w - ONE)) == '0);
    endfunction

    function automatic logic [IDXW-1:0] encode(input logic [WIDTH-1:0] w);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Stage p0: combinational classification of the incoming sample
    logic [WIDTH-1:0] sample_p0;
    logic             vld_p0;
    logic             legal_p0;
    logic             in_seq_p0;
    logic [IDXW-1:0]  enc_p0;
    logic [3:0]       streak_inc_p0;

    state_t           state_p1;
    logic [WIDTH-1:0] prev_p1;
    logic [3:0]       streak_p1;
    logic [IDXW-1:0]  index_p1;
    logic             vld_p1;
    logic             locked_p1;
    logic             wrap_p1;
    logic             err_p1;
    logic [7:0]       err_cnt_p1;

    assign sample_p0     = bus.count_in;
    assign vld_p0        = bus.in_valid;
    assign legal_p0      = is_onehot(sample_p0);
    assign enc_p0        = encode(sample_p0);
    // A repeated word never equals its own rotation, so it falls out as out-of-sequence.
    assign in_seq_p0     = (sample_p0 == {prev_p1[0], prev_p1[WIDTH-1:1]});
    assign streak_inc_p0 = streak_p1 + 4'd1;

    // Stage p1: sequence FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1   <= HUNT;
            prev_p1    <= '0;
            streak_p1  <= '0;
            index_p1   <= '0;
            vld_p1     <= 1'b0;
            locked_p1  <= 1'b0;
            wrap_p1    <= 1'b0;
            err_p1     <= 1'b0;
            err_cnt_p1 <= '0;
        end else begin
            vld_p1  <= 1'b0;
            wrap_p1 <= 1'b0;
            err_p1  <= 1'b0;
            if (vld_p0) begin
                if (!legal_p0) begin
                    err_p1     <= 1'b1;
                    err_cnt_p1 <= sat_inc(err_cnt_p1);
                    prev_p1    <= '0;
                    streak_p1  <= '0;
                    state_p1   <= HUNT;
                    locked_p1  <= 1'b0;
                end else begin
                    prev_p1  <= sample_p0;
                    index_p1 <= enc_p0;
                    unique case (state_p1)
                        HUNT: begin
                            streak_p1 <= '0;
                            state_p1  <= CHECK;
                            locked_p1 <= 1'b0;
                        end
                        CHECK: begin
                            if (in_seq_p0) begin
                                streak_p1 <= streak_inc_p0;
                                if (streak_inc_p0 == LOCK_V) begin
                                    state_p1  <= LOCKED;
                                    locked_p1 <= 1'b1;
                                    vld_p1    <= 1'b1;
                                end
                            end else begin
                                streak_p1 <= '0;
                            end
                        end
                        LOCKED: begin
                            if (in_seq_p0) begin
                                vld_p1  <= 1'b1;
                                wrap_p1 <= (enc_p0 == '0);
                            end else begin
                                err_p1     <= 1'b1;
                                err_cnt_p1 <= sat_inc(err_cnt_p1);
                                streak_p1  <= '0;
                                state_p1   <= CHECK;
                                locked_p1  <= 1'b0;
                            end
                        end
                        default: begin
                            state_p1  <= HUNT;
                            locked_p1 <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.index       = index_p1;
    assign bus.index_valid = vld_p1;
    assign bus.locked      = locked_p1;
    assign bus.wrap_pulse  = wrap_p1;
    assign bus.err_pulse   = err_p1;
    assign bus.err_count   = err_cnt_p1;
endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder (WIDTH=4, LOCK_N=3): directed table,
// reset/gap/saturation sequences and a random stream against a reference model.
module tb_ring_decoder;
    localparam int W = 4;
    localparam int L = 3;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    ring_if #(.WIDTH(W), .IDXW(2)) bus ();

    ring_decoder #(.WIDTH(W), .LOCK_N(L), .IDXW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the last legal position and the length of the
    // current run of correct rotations; locked means that run reached L.
    int m_prev;
    int m_run;
    int m_idx, m_iv, m_lk, m_wr, m_er, m_ec;

    function automatic void model_reset();
        m_prev = -1; m_run = 0;
        m_idx = 0; m_iv = 0; m_lk = 0; m_wr = 0; m_er = 0; m_ec = 0;
    endfunction

    function automatic void model_step(input logic [W-1:0] w, input bit v);
        int  p;
        bit  was_locked;
        bit  in_seq;
        m_iv = 0; m_wr = 0; m_er = 0;
        if (!v) return;
        if ($countones(w) != 1) begin
            m_er = 1;
            if (m_ec < 255) m_ec++;
            m_prev = -1;
            m_run  = 0;
        end else begin
            p = 0;
            for (int i = 0; i < W; i++) if (w[i]) p = i;
            was_locked = (m_run >= L);
            in_seq = (m_prev >= 0) && (p == (m_prev + W - 1) % W);
            if (in_seq) begin
                m_run++;
                m_iv = (m_run >= L);
                m_wr = was_locked && (p == 0);
            end else begin
                if (was_locked) begin
                    m_er = 1;
                    if (m_ec < 255) m_ec++;
                end
                m_run = 0;
            end
            m_prev = p;
            m_idx  = p;
        end
        m_lk = (m_run >= L);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_all(input string tag, input int idx, input int iv, input int lk,
                           input int wr, input int er, input int ec);
        chk({tag, ".index"},       int'(bus.index),       idx);
        chk({tag, ".index_valid"}, int'(bus.index_valid), iv);
        chk({tag, ".locked"},      int'(bus.locked),      lk);
        chk({tag, ".wrap_pulse"},  int'(bus.wrap_pulse),  wr);
        chk({tag, ".err_pulse"},   int'(bus.err_pulse),   er);
        chk({tag, ".err_count"},   int'(bus.err_count),   ec);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_idx, m_iv, m_lk, m_wr, m_er, m_ec);
    endtask

    task automatic cyc(input logic [W-1:0] w, input bit v);
        @(negedge clk);
        bus.count_in = w;
        bus.in_valid = v;
        @(posedge clk);
        #1;
        model_step(w, v);
    endtask

    // Asserts reset away from any clock edge and checks the asynchronous clear.
    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_all(tag, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [W-1:0] w;
        bit           v;
        int           idx, iv, lk, wr, er, ec;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [W-1:0] w;
        int           last;
        n_pass = 0;
        n_total = 0;
        bus.count_in = '0;
        bus.in_valid = 1'b0;
        model_reset();

        //               w        v  idx iv lk wr er ec
        tbl[0]  = '{4'b0001, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{4'b1000, 1, 3, 0, 0, 0, 0, 0};
        tbl[2]  = '{4'b0100, 1, 2, 0, 0, 0, 0, 0};
        tbl[3]  = '{4'b0010, 1, 1, 1, 1, 0, 0, 0};
        tbl[4]  = '{4'b0001, 1, 0, 1, 1, 1, 0, 0};
        tbl[5]  = '{4'b0100, 1, 2, 0, 0, 0, 1, 1};
        tbl[6]  = '{4'b0010, 1, 1, 0, 0, 0, 0, 1};
        tbl[7]  = '{4'b0001, 1, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{4'b1000, 1, 3, 1, 1, 0, 0, 1};
        tbl[9]  = '{4'b0000, 0, 3, 0, 1, 0, 0, 1};
        tbl[10] = '{4'b0100, 1, 2, 1, 1, 0, 0, 1};
        tbl[11] = '{4'b0110, 1, 2, 0, 0, 0, 1, 2};
        tbl[12] = '{4'b0000, 1, 2, 0, 0, 0, 1, 3};
        tbl[13] = '{4'b0010, 1, 1, 0, 0, 0, 0, 3};
        tbl[14] = '{4'b0010, 1, 1, 0, 0, 0, 0, 3};

        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk_all("reset_async", 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, 1'b0);
            chk_all("idle_after_reset", 0, 0, 0, 0, 0, 0);
        end

        // Directed vectors: lock, wrap, break, relock, gap, illegal, repeat
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].w, tbl[i].v);
            chk_all($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].iv, tbl[i].lk,
                    tbl[i].wr, tbl[i].er, tbl[i].ec);
        end

        // Locked stream with idle gaps
        do_reset("reset_before_gaps");
        cyc(4'b0001, 1'b1); cyc(4'b1000, 1'b1); cyc(4'b0100, 1'b1); cyc(4'b0010, 1'b1);
        chk_all("gap_lock", 1, 1, 1, 0, 0, 0);
        last = 1;
        for (int k = 0; k < 8; k++) begin
            int gap;
            gap = $urandom_range(1, 5);
            for (int g = 0; g < gap; g++) begin
                cyc(4'($urandom_range(0, 15)), 1'b0);
                chk_all($sformatf("gap%0d_idle%0d", k, g), last, 0, 1, 0, 0, 0);
            end
            last = (last + W - 1) % W;
            w = 4'(1 << last);
            cyc(w, 1'b1);
            chk_all($sformatf("gap%0d_valid", k), last, 1, 1, (last == 0) ? 1 : 0, 0, 0);
        end

        // Reset while locked, then the first sample must be treated from HUNT
        do_reset("reset_while_locked");
        cyc(4'b0100, 1'b1);
        chk_all("post_reset_hunt", 2, 0, 0, 0, 0, 0);
        cyc(4'b0010, 1'b1);
        chk_all("post_reset_check", 1, 0, 0, 0, 0, 0);

        // Error counter saturation
        do_reset("reset_before_sat");
        for (int i = 0; i < 260; i++) begin
            w = (i % 2 == 0) ? 4'b0000 : 4'b1011;
            cyc(w, 1'b1);
            if (i == 253) chk("sat_count_254", int'(bus.err_count), 254);
            if (i == 254) chk("sat_count_255", int'(bus.err_count), 255);
        end
        chk("sat_hold", int'(bus.err_count), 255);
        chk("sat_pulse", int'(bus.err_pulse), 1);
        cyc(4'b0001, 1'b0);
        chk("sat_pulse_clears", int'(bus.err_pulse), 0);
        do_reset("reset_after_sat");

        // Randomized stream against the reference model
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_prev >= 0 && r < 70)
                w = 4'(1 << ((m_prev + W - 1) % W));
            else if (r < 88)
                w = 4'(1 << $urandom_range(0, W - 1));
            else
                w = 4'($urandom_range(0, 15));
            cyc(w, ($urandom_range(0, 9) < 8));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
